// File: rtl/rx_hdr_parse_if.sv
// rtl/rx_hdr_parse_if.sv - link, rx buffer read port and header/address handshake bundle
interface rx_hdr_parse_if #(
    parameter int AW = 11
);
    logic          rx_start;
    logic          rx_done;
    logic [1:0]    rx_crc_rslt;
    logic          hdr_buf_rden;
    logic [AW-1:0] hdr_buf_raddr;
    logic [7:0]    hdr_buf_rdata;
    logic [7:0]    DA;
    logic [7:0]    FC;
    logic [7:0]    MODE;
    logic          read_done;
    logic          addr_read_reg;
    logic [23:0]   ADDR;
    logic          addr_read_done;
    logic [15:0]   frame_ok_cnt;
    logic [15:0]   crc_err_cnt;

    modport master (
        input  rx_start, rx_done, rx_crc_rslt, hdr_buf_rdata, addr_read_reg,
        output hdr_buf_rden, hdr_buf_raddr, DA, FC, MODE, read_done,
               ADDR, addr_read_done, frame_ok_cnt, crc_err_cnt
    );

    modport slave (
        output rx_start, rx_done, rx_crc_rslt, hdr_buf_rdata, addr_read_reg,
        input  hdr_buf_rden, hdr_buf_raddr, DA, FC, MODE, read_done,
               ADDR, addr_read_done, frame_ok_cnt, crc_err_cnt
    );
endinterface

// File: rtl/rx_hdr_parse.sv
// rtl/rx_hdr_parse.sv - frame header extractor reading DA/FC/MODE and on-demand ADDR from rx buffer
module rx_hdr_parse #(
    parameter int DA_OFS   = 0,
    parameter int FC_OFS   = 2,
    parameter int MODE_OFS = 3,
    parameter int ADDR_OFS = 5,
    parameter int AW       = 11
) (
    input logic            clk,
    input logic            reset,
    rx_hdr_parse_if.master bus
);
    typedef enum logic [2:0] {IDLE, HDR_RD, HDR_VAL, ADR_RD, ADR_VAL} state_t;

    state_t        state_q, state_d;
    logic [1:0]    cnt_q, cnt_d;
    logic          rx_done_d, rx_start_d;
    logic          rise, start_rise, crc_good, req;
    logic [7:0]    da_q, fc_q, mode_q, addr_hi_q, addr_mid_q;
    logic [23:0]   addr_q;
    logic          read_done_q, addr_done_q;
    logic [15:0]   frame_ok_q, crc_err_q;
    logic          rden;
    logic [AW-1:0] raddr;
    logic          unused_crc;

    assign rise       = bus.rx_done & ~rx_done_d;
    assign start_rise = bus.rx_start & ~rx_start_d;
    assign crc_good   = bus.rx_crc_rslt[0];
    assign req        = bus.addr_read_reg;
    assign unused_crc = bus.rx_crc_rslt[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // A new frame (or a new reception start) preempts whatever is in flight.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rden    = 1'b0;
        raddr   = '0;
        case (state_q)
            HDR_RD: begin
                rden  = (cnt_q != 2'd3);
                raddr = (cnt_q == 2'd0) ? AW'(DA_OFS) :
                        (cnt_q == 2'd1) ? AW'(FC_OFS) : AW'(MODE_OFS);
            end
            ADR_RD: begin
                rden  = (cnt_q != 2'd3);
                raddr = AW'(ADDR_OFS + 32'(cnt_q));
            end
            default: ;
        endcase
        if (rise) begin
            state_d = crc_good ? HDR_RD : IDLE;
            cnt_d   = 2'd0;
        end else if (start_rise) begin
            state_d = IDLE;
            cnt_d   = 2'd0;
        end else begin
            case (state_q)
                HDR_RD: begin
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) state_d = HDR_VAL;
                end
                HDR_VAL: if (req) begin
                    state_d = ADR_RD;
                    cnt_d   = 2'd0;
                end
                ADR_RD: begin
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) state_d = ADR_VAL;
                end
                ADR_VAL: if (!req) state_d = HDR_VAL;
                default: ;
            endcase
        end
    end

    // Read data lags its address by one clock, so capture uses count 1..3.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_done_d   <= 1'b0;
            rx_start_d  <= 1'b0;
            da_q        <= 8'd0;
            fc_q        <= 8'd0;
            mode_q      <= 8'd0;
            addr_hi_q   <= 8'd0;
            addr_mid_q  <= 8'd0;
            addr_q      <= 24'd0;
            read_done_q <= 1'b0;
            addr_done_q <= 1'b0;
            frame_ok_q  <= 16'd0;
            crc_err_q   <= 16'd0;
        end else begin
            rx_done_d  <= bus.rx_done;
            rx_start_d <= bus.rx_start;
            if (rise) begin
                read_done_q <= 1'b0;
                addr_done_q <= 1'b0;
                if (crc_good) begin
                    if (frame_ok_q != 16'hFFFF) frame_ok_q <= frame_ok_q + 16'd1;
                end else begin
                    if (crc_err_q != 16'hFFFF) crc_err_q <= crc_err_q + 16'd1;
                end
            end else if (start_rise) begin
                read_done_q <= 1'b0;
                addr_done_q <= 1'b0;
            end else begin
                case (state_q)
                    HDR_RD: case (cnt_q)
                        2'd1: da_q <= bus.hdr_buf_rdata;
                        2'd2: fc_q <= bus.hdr_buf_rdata;
                        2'd3: begin
                            mode_q      <= bus.hdr_buf_rdata;
                            read_done_q <= 1'b1;
                        end
                        default: ;
                    endcase
                    ADR_RD: case (cnt_q)
                        2'd1: addr_hi_q  <= bus.hdr_buf_rdata;
                        2'd2: addr_mid_q <= bus.hdr_buf_rdata;
                        2'd3: begin
                            addr_q      <= {addr_hi_q, addr_mid_q, bus.hdr_buf_rdata};
                            addr_done_q <= 1'b1;
                        end
                        default: ;
                    endcase
                    ADR_VAL: if (!req) addr_done_q <= 1'b0;
                    default: ;
                endcase
            end
        end
    end

    assign bus.hdr_buf_rden   = rden;
    assign bus.hdr_buf_raddr  = raddr;
    assign bus.DA             = da_q;
    assign bus.FC             = fc_q;
    assign bus.MODE           = mode_q;
    assign bus.read_done      = read_done_q;
    assign bus.ADDR           = addr_q;
    assign bus.addr_read_done = addr_done_q;
    assign bus.frame_ok_cnt   = frame_ok_q;
    assign bus.crc_err_cnt    = crc_err_q;
endmodule
